// File: rtl/gray_counter_pkg.sv
// Shared helpers for the Gray-code LED counter: Gray conversion and prescaler sizing.
package gray_counter_pkg;

   localparam int unsigned MAX_W = 64;

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // $clog2(1) is 0, so a single-cycle interval still needs a 1-bit counter
   function automatic int unsigned cnt_width(input int unsigned distance);
      return (distance > 2) ? $clog2(distance) : 1;
   endfunction

endpackage

// File: rtl/gray_counter_if.sv
// LED bus carrying the registered Gray-code count from the counter to its observer.
interface gray_counter_if #(
   parameter int unsigned N = 8
);
   logic [N-1:0] leds;

   modport master (output leds);
   modport slave  (input  leds);
endinterface

// File: rtl/gray_counter_system_tick.sv
// Prescaler: counts 0..distance-1 and raises step combinationally on the last count.
module gray_tick_gen
   import gray_counter_pkg::*;
#(
   parameter int unsigned distance = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic step
);

   localparam int unsigned W = cnt_width(distance);
   localparam logic [W-1:0] LAST = W'(distance - 1);

   logic [W-1:0] pc;

   assign step = (pc == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= '0;
      end else if (step) begin
         pc <= '0;
      end else begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/gray_counter_system.sv
// LED demo top: binary counter advanced by the prescaler, with leds holding its Gray code.
module gray_counter_system
   import gray_counter_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned distance = 1000
) (
   input  logic         clk,
   input  logic         reset,
   output logic [N-1:0] leds
);

   logic         step;
   logic [N-1:0] bin;
   logic [N-1:0] bin_next;

   gray_tick_gen #(.distance(distance)) u_tick (
      .clk   (clk),
      .reset (reset),
      .step  (step)
   );

   assign bin_next = bin + 1'b1;

   // leds is loaded from bin_next so it tracks bin with no extra latency stage
   always_ff @(posedge clk) begin
      if (reset) begin
         bin  <= '0;
         leds <= '0;
      end else if (step) begin
         bin  <= bin_next;
         leds <= N'(bin2gray(MAX_W'(bin_next)));
      end
   end

endmodule

// File: tb/tb_gray_counter_system.sv
// Bench for gray_counter_system: three configurations checked against an edge-count model.
module tb_gray_counter_system;

   logic clk = 1'b0;
   logic ra = 1'b1;
   logic rb = 1'b1;
   logic rc = 1'b1;

   always #5 clk = ~clk;

   gray_counter_if #(.N(4)) ifa ();
   gray_counter_if #(.N(4)) ifb ();
   gray_counter_if #(.N(8)) ifc ();

   gray_counter_system #(.N(4), .distance(4)) dut_a (
      .clk(clk), .reset(ra), .leds(ifa.leds));
   gray_counter_system #(.N(4), .distance(1)) dut_b (
      .clk(clk), .reset(rb), .leds(ifb.leds));
   gray_counter_system #(.N(8), .distance(1000)) dut_c (
      .clk(clk), .reset(rc), .leds(ifc.leds));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned gray(input int unsigned v);
      return v ^ (v >> 1);
   endfunction

   // Reference model: edges since the last reset edge; expected steps = edges / distance.
   int unsigned ea = 0, eb = 0, ec = 0;
   bit started = 1'b0;

   always @(posedge clk) begin
      started <= 1'b1;
      ea <= ra ? 0 : ea + 1;
      eb <= rb ? 0 : eb + 1;
      ec <= rc ? 0 : ec + 1;
   end

   logic [3:0] a_prev = '0;

   always @(negedge clk) begin
      if (started) begin
         check("model_a", 64'(ifa.leds), 64'(gray((ea / 4) % 16)));
         check("model_b", 64'(ifb.leds), 64'(gray(eb % 16)));
         check("model_c", 64'(ifc.leds), 64'(gray((ec / 1000) % 256)));
         if (ea != 0 && ea % 4 == 0)
            check("single_bit_a", 64'($countones(ifa.leds ^ a_prev)), 64'd1);
         a_prev = ifa.leds;
      end
   end

   logic [3:0] seq [17];
   bit c_done = 1'b0;

   initial begin
      wait (rc == 1'b0);
      repeat (1000) @(posedge clk);
      #2 check("c_edge1000", 64'(ifc.leds), 64'h01);
      repeat (1000) @(posedge clk);
      #2 check("c_edge2000", 64'(ifc.leds), 64'h03);
      c_done = 1'b1;
   end

   initial begin
      seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
              4'b0000};

      repeat (5) @(posedge clk);
      #2;
      check("reset_a", 64'(ifa.leds), 64'h0);
      check("reset_b", 64'(ifb.leds), 64'h0);
      check("reset_c", 64'(ifc.leds), 64'h0);
      ra = 1'b0; rb = 1'b0; rc = 1'b0;

      // 16 full steps of the distance=4 counter plus the wrap back to 0
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk); #2;
         if (i <= 3) check("a_hold", 64'(ifa.leds), 64'h0);
         if (i % 4 == 0) check("a_seq", 64'(ifa.leds), 64'(seq[i / 4]));
         if (i == 5) check("b_after5", 64'(ifb.leds), 64'b0111);
      end

      // two more wraps, then stop at pc=2 with leds=0011
      repeat (138) @(posedge clk);
      #2 check("a_mid", 64'(ifa.leds), 64'b0011);
      ra = 1'b1;
      @(posedge clk); #2;
      check("a_mid_reset", 64'(ifa.leds), 64'h0);
      ra = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #2;
         check("a_restart", 64'(ifa.leds), (i == 4) ? 64'h1 : 64'h0);
      end

      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(1, 30)) @(posedge clk);
         #2;
         if ($urandom_range(0, 1) == 1) begin
            ra = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2 ra = 1'b0;
         end
      end

      for (int i = 0; i < 3000 && !c_done; i++) @(posedge clk);
      if (!c_done) begin
         n_cmp++;
         n_err++;
         $display("FAIL c_timeout: got not_done expected done");
      end
      @(posedge clk); #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
